// File: rtl/raifes_mul_div_param_pkg.sv
// Shared encodings for the raifes multiply/divide unit: MD op / output-select
// codes, sequencer states and the iteration-counter width helper.
package raifes_mul_div_param_pkg;

    localparam int unsigned MD_OP_WIDTH      = 2;
    localparam int unsigned MD_OUT_SEL_WIDTH = 2;

    typedef enum logic [MD_OP_WIDTH-1:0] {
        MD_OP_MUL = 2'd0,
        MD_OP_DIV = 2'd1,
        MD_OP_REM = 2'd2
    } md_op_e;

    typedef enum logic [MD_OUT_SEL_WIDTH-1:0] {
        MD_OUT_LO  = 2'd0,
        MD_OUT_HI  = 2'd1,
        MD_OUT_REM = 2'd2
    } md_out_sel_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_SETUP   = 2'd2,
        S_DONE    = 2'd3
    } md_state_e;

    function automatic int unsigned md_ctr_width(input int unsigned xlen, input int unsigned step);
        return $clog2(xlen / step);
    endfunction

endpackage

// File: rtl/raifes_md_div_step.sv
// One restoring-division stage: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and report the quotient bit.
module raifes_md_div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic            i_bit,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic            o_q
);

    logic [XLEN:0] w_shifted;

    // Incoming remainder is below the divisor, so the result always fits in XLEN bits.
    assign w_shifted = {i_rem, i_bit};
    assign o_q       = (w_shifted >= {1'b0, i_div});
    assign o_rem     = o_q ? XLEN'(w_shifted - {1'b0, i_div}) : w_shifted[XLEN-1:0];

endmodule

// File: rtl/raifes_mul_div_param.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide retiring STEP bits per cycle, with kill, back-pressure and divide fast paths.
module raifes_mul_div_param
    import raifes_mul_div_param_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned STEP = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_kill,
    input  logic [MD_OP_WIDTH-1:0]      req_op,
    input  logic [MD_OUT_SEL_WIDTH-1:0] req_out_sel,
    input  logic                        req_in_1_signed,
    input  logic                        req_in_2_signed,
    input  logic [XLEN-1:0]             req_in_1,
    input  logic [XLEN-1:0]             req_in_2,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [XLEN-1:0]             resp_result
);

    localparam int unsigned     CW       = md_ctr_width(XLEN, STEP);
    localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN / STEP - 1);

    md_state_e                   r_state;
    md_state_e                   w_state_nxt;
    logic [XLEN-1:0]             r_a;
    logic [XLEN-1:0]             r_b;
    logic [2*XLEN-1:0]           r_acc;
    logic [XLEN-1:0]             r_rem;
    logic [CW-1:0]               r_cnt;
    logic [MD_OP_WIDTH-1:0]      r_op;
    logic [MD_OUT_SEL_WIDTH-1:0] r_out_sel;
    logic                        r_negate;
    logic [XLEN-1:0]             r_result;

    logic                        w_accept;
    logic                        w_neg1;
    logic                        w_neg2;
    logic [XLEN-1:0]             w_abs1;
    logic [XLEN-1:0]             w_abs2;
    logic                        w_is_div;
    logic                        w_div_zero;
    logic                        w_ovf;
    logic                        w_special;
    logic                        w_negate_in;

    logic [2*XLEN-1:0]           w_mul_acc;
    logic [XLEN-1:0]             w_mul_b;
    logic [XLEN-1:0]             w_rem_chain [STEP+1];
    logic [STEP-1:0]             w_qbits;

    logic [2*XLEN-1:0]           w_sel;
    logic [2*XLEN-1:0]           w_signed_res;
    logic [XLEN-1:0]             w_setup_result;

    // Request decode: operand magnitudes, result sign and divide fast paths
    assign w_neg1      = req_in_1_signed & req_in_1[XLEN-1];
    assign w_neg2      = req_in_2_signed & req_in_2[XLEN-1];
    assign w_abs1      = w_neg1 ? (~req_in_1 + 1'b1) : req_in_1;
    assign w_abs2      = w_neg2 ? (~req_in_2 + 1'b1) : req_in_2;
    assign w_is_div    = (req_op == MD_OP_DIV) || (req_op == MD_OP_REM);
    assign w_div_zero  = (req_in_2 == '0);
    assign w_ovf       = req_in_1_signed && req_in_2_signed &&
                         (req_in_1 == {1'b1, {(XLEN-1){1'b0}}}) && (req_in_2 == '1);
    assign w_special   = w_is_div && (w_div_zero || w_ovf);
    assign w_negate_in = (req_op == MD_OP_REM) ? w_neg1 : (w_neg1 ^ w_neg2);
    // Kill wins over a same-cycle request even though it is otherwise a no-op in IDLE
    assign w_accept    = req_valid && req_ready && !req_kill;

    always_comb begin
        w_mul_acc = r_acc;
        w_mul_b   = r_b;
        for (int unsigned i = 0; i < STEP; i++) begin
            w_mul_acc = {w_mul_acc[2*XLEN-2:0], 1'b0} +
                        (w_mul_b[XLEN-1] ? {{XLEN{1'b0}}, r_a} : {(2*XLEN){1'b0}});
            w_mul_b   = {w_mul_b[XLEN-2:0], 1'b0};
        end
    end

    assign w_rem_chain[0] = r_rem;

    for (genvar g = 0; g < STEP; g++) begin : g_div
        raifes_md_div_step #(
            .XLEN(XLEN)
        ) u_step (
            .i_rem (w_rem_chain[g]),
            .i_bit (r_a[XLEN-1-g]),
            .i_div (r_b),
            .o_rem (w_rem_chain[g+1]),
            .o_q   (w_qbits[STEP-1-g])
        );
    end

    assign w_sel          = (r_op == MD_OP_REM) ? {{XLEN{1'b0}}, r_rem} : r_acc;
    assign w_signed_res   = r_negate ? (~w_sel + 1'b1) : w_sel;
    assign w_setup_result = (r_out_sel == MD_OUT_HI) ? w_signed_res[2*XLEN-1:XLEN]
                                                     : w_signed_res[XLEN-1:0];

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = w_special ? S_SETUP : S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (req_kill) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nxt = req_kill ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                if (req_kill || resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_op      <= '0;
            r_out_sel <= '0;
            r_negate  <= 1'b0;
            r_result  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= req_op;
                        r_out_sel <= req_out_sel;
                        r_cnt     <= CNT_INIT;
                        r_a       <= w_abs1;
                        r_b       <= w_abs2;
                        r_acc     <= '0;
                        r_rem     <= '0;
                        r_negate  <= w_negate_in;
                        // Fast paths preload the final quotient/remainder and skip COMPUTE
                        if (w_is_div && w_div_zero) begin
                            r_acc    <= '1;
                            r_rem    <= req_in_1;
                            r_negate <= 1'b0;
                        end else if (w_is_div && w_ovf) begin
                            r_acc    <= {{XLEN{1'b0}}, req_in_1};
                            r_rem    <= '0;
                            r_negate <= 1'b0;
                        end
                    end
                end
                S_COMPUTE: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_op == MD_OP_MUL) begin
                        r_acc <= w_mul_acc;
                        r_b   <= w_mul_b;
                    end else begin
                        r_rem <= w_rem_chain[STEP];
                        r_acc <= {r_acc[2*XLEN-1-STEP:0], w_qbits};
                        r_a   <= {r_a[XLEN-1-STEP:0], {STEP{1'b0}}};
                    end
                end
                S_SETUP: begin
                    r_result <= w_setup_result;
                end
                default: begin
                end
            endcase
        end
    end

    assign resp_result = r_result;

endmodule

// File: tb/tb_raifes_mul_div_param.sv
// Scoreboard bench for raifes_mul_div_param: directed RV32M cases, back-pressure,
// kill and reset, plus randomized traffic on a 32/1 and a 64/4 instance.
module tb_raifes_mul_div_param;
    import raifes_mul_div_param_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid64, req_kill, resp_ready;
    logic [1:0]  t_op, t_sel;
    logic        t_s1, t_s2;
    logic [63:0] t_in1, t_in2;
    logic        req_ready, resp_valid, req_ready64, resp_valid64;
    logic [31:0] resp_result;
    logic [63:0] resp_result64;
    bit          rr_random;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [63:0] sb32[$];
    logic [63:0] sb64[$];

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  sel;
        logic        s1;
        logic        s2;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int unsigned lat;
    } vec_t;

    always #5 clk = ~clk;

    raifes_mul_div_param #(.XLEN(32), .STEP(1)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_kill(req_kill), .req_op(t_op), .req_out_sel(t_sel),
        .req_in_1_signed(t_s1), .req_in_2_signed(t_s2),
        .req_in_1(t_in1[31:0]), .req_in_2(t_in2[31:0]),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result)
    );

    raifes_mul_div_param #(.XLEN(64), .STEP(4)) u_dut64 (
        .clk(clk), .reset(reset), .req_valid(req_valid64), .req_ready(req_ready64),
        .req_kill(req_kill), .req_op(t_op), .req_out_sel(t_sel),
        .req_in_1_signed(t_s1), .req_in_2_signed(t_s2),
        .req_in_1(t_in1), .req_in_2(t_in2),
        .resp_valid(resp_valid64), .resp_ready(resp_ready), .resp_result(resp_result64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: sign/zero-extend to 128 bits and use plain arithmetic
    function automatic logic [63:0] model(input int unsigned xl, input logic [1:0] op,
                                          input logic [1:0] sel, input logic s1, input logic s2,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [63:0]         mask;
        logic [127:0]        ea, eb, p;
        logic signed [127:0] q, r;
        mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        ea = {64'd0, a & mask};
        eb = {64'd0, b & mask};
        if (s1 && a[xl-1]) ea = ea | ~((128'd1 << xl) - 128'd1);
        if (s2 && b[xl-1]) eb = eb | ~((128'd1 << xl) - 128'd1);
        if (op == MD_OP_MUL) begin
            p = ea * eb;
            return (sel == MD_OUT_HI) ? (64'(p >> xl) & mask) : (p[63:0] & mask);
        end
        if ((b & mask) == 64'd0) begin
            q = '1;
            r = $signed(ea);
        end else if (s1 && s2 && (a & mask) == (64'd1 << (xl - 1)) && (b & mask) == mask) begin
            q = $signed(ea);
            r = '0;
        end else begin
            q = $signed(ea) / $signed(eb);
            r = $signed(ea) % $signed(eb);
        end
        return (op == MD_OP_REM) ? (r[63:0] & mask) : (q[63:0] & mask);
    endfunction

    task automatic issue(input bit w64, input logic [1:0] op, input logic [1:0] sel,
                         input logic s1, input logic s2, input logic [63:0] a,
                         input logic [63:0] b, input bit push, input logic [63:0] exp);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        t_op = op; t_sel = sel; t_s1 = s1; t_s2 = s2; t_in1 = a; t_in2 = b;
        if (w64) req_valid64 = 1'b1; else req_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (w64 ? req_ready64 : req_ready) begin
                ok = 1;
                break;
            end
        end
        if (ok) begin
            if (push) begin
                if (w64) sb64.push_back(exp); else sb32.push_back(exp);
            end
        end else begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: req_ready stayed 0, required 1");
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_valid64 = 1'b0;
    endtask

    // lat counts clock edges from the accepting edge to the first resp_valid cycle
    task automatic wait_resp(input bit w64, output int unsigned lat, output bit rdy_seen);
        lat = 1;
        rdy_seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (w64 ? req_ready64 : req_ready) rdy_seen = 1;
            if (w64 ? resp_valid64 : resp_valid) return;
            @(posedge clk);
            lat++;
        end
        lat = 0;
    endtask

    task automatic rand_req(input bit w64);
        logic [1:0]  op, sel;
        logic        s1, s2;
        logic [63:0] a, b, mask;
        int unsigned xl, k;
        xl   = w64 ? 64 : 32;
        mask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        op   = 2'($urandom_range(0, 2));
        sel  = (op == MD_OP_MUL) ? ($urandom_range(0, 1) ? MD_OUT_HI : MD_OUT_LO)
                                 : ((op == MD_OP_DIV) ? MD_OUT_LO : MD_OUT_REM);
        s1   = 1'($urandom_range(0, 1));
        s2   = 1'($urandom_range(0, 1));
        a    = {$urandom, $urandom} & mask;
        b    = {$urandom, $urandom} & mask;
        k    = $urandom_range(0, 7);
        if (k == 0) b = '0;
        else if (k == 1) begin s1 = 1; s2 = 1; a = 64'd1 << (xl - 1); b = mask; end
        else if (k == 2) b = 64'($urandom_range(1, 20));
        else if (k == 3) a = 64'($urandom_range(0, 1000));
        issue(w64, op, sel, s1, s2, a, b, 1, model(xl, op, sel, s1, s2, a, b));
    endtask

    always @(negedge clk) begin
        if (!reset && resp_valid && resp_ready) begin
            if (sb32.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL resp32_unexpected: got 0x%0h with no request outstanding", resp_result);
            end else begin
                chk("resp32", {32'd0, resp_result}, sb32.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && resp_valid64 && resp_ready) begin
            if (sb64.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL resp64_unexpected: got 0x%0h with no request outstanding", resp_result64);
            end else begin
                chk("resp64", resp_result64, sb64.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (rr_random) begin
            #1 resp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        vec_t        vecs[12];
        int unsigned lat;
        bit          rdy;
        int unsigned vseen;

        vecs = '{
            '{MD_OP_MUL, MD_OUT_LO,  1, 1, 64'h7,        64'hFFFFFFFD, 64'hFFFFFFEB, 34},
            '{MD_OP_MUL, MD_OUT_HI,  0, 0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 34},
            '{MD_OP_MUL, MD_OUT_HI,  1, 1, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000000, 34},
            '{MD_OP_MUL, MD_OUT_HI,  1, 0, 64'hFFFFFFFF, 64'h2,        64'hFFFFFFFF, 34},
            '{MD_OP_DIV, MD_OUT_LO,  1, 1, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, 34},
            '{MD_OP_REM, MD_OUT_REM, 1, 1, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, 34},
            '{MD_OP_DIV, MD_OUT_LO,  0, 0, 64'd100,      64'd7,        64'd14,       34},
            '{MD_OP_REM, MD_OUT_REM, 0, 0, 64'd100,      64'd7,        64'd2,        34},
            '{MD_OP_DIV, MD_OUT_LO,  0, 0, 64'd5,        64'd0,        64'hFFFFFFFF, 2},
            '{MD_OP_REM, MD_OUT_REM, 1, 1, 64'd5,        64'd0,        64'd5,        2},
            '{MD_OP_DIV, MD_OUT_LO,  1, 1, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 2},
            '{MD_OP_REM, MD_OUT_REM, 1, 1, 64'h80000000, 64'hFFFFFFFF, 64'h00000000, 2}
        };

        reset = 1'b1; req_valid = 1'b0; req_valid64 = 1'b0; req_kill = 1'b0;
        resp_ready = 1'b1; rr_random = 0;
        t_op = '0; t_sel = '0; t_s1 = 0; t_s2 = 0; t_in1 = '0; t_in2 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        chk("reset_resp_result", 64'(resp_result), 64'd0);

        foreach (vecs[i]) begin
            issue(0, vecs[i].op, vecs[i].sel, vecs[i].s1, vecs[i].s2, vecs[i].a, vecs[i].b, 1, vecs[i].exp);
            wait_resp(0, lat, rdy);
            chk($sformatf("latency_vec%0d", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("ready_low_vec%0d", i), 64'(rdy), 64'd0);
        end

        // Back-pressure: result and handshake held while the consumer stalls
        @(posedge clk); #1 resp_ready = 1'b0;
        issue(0, MD_OP_DIV, MD_OUT_LO, 0, 0, 64'd100, 64'd7, 1, 64'd14);
        wait_resp(0, lat, rdy);
        chk("hold_latency", 64'(lat), 64'd34);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            chk("hold_result", 64'(resp_result), 64'd14);
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("release_req_ready", 64'(req_ready), 64'd1);
        chk("release_resp_valid", 64'(resp_valid), 64'd0);

        // Kill at compute cycle 10: no response, then a fresh request completes
        issue(0, MD_OP_DIV, MD_OUT_LO, 0, 0, 64'd1000, 64'd3, 0, 64'd0);
        repeat (9) @(posedge clk);
        #1 req_kill = 1'b1;
        @(posedge clk); #1 req_kill = 1'b0;
        @(negedge clk);
        chk("kill_req_ready", 64'(req_ready), 64'd1);
        vseen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid) vseen++;
        end
        chk("kill_no_resp", 64'(vseen), 64'd0);
        issue(0, MD_OP_DIV, MD_OUT_LO, 0, 0, 64'd1000, 64'd3, 1, 64'd333);
        wait_resp(0, lat, rdy);
        chk("after_kill_latency", 64'(lat), 64'd34);

        // Randomized traffic with random back-pressure
        rr_random = 1;
        for (int i = 0; i < 150; i++) rand_req(0);
        for (int i = 0; i < 300 && sb32.size() != 0; i++) @(posedge clk);
        rr_random = 0;
        @(posedge clk); #2 resp_ready = 1'b1;

        // Reset in the middle of COMPUTE
        issue(0, MD_OP_MUL, MD_OUT_LO, 0, 0, 64'd12345, 64'd678, 0, 64'd0);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("midreset_req_ready", 64'(req_ready), 64'd1);
        chk("midreset_resp_valid", 64'(resp_valid), 64'd0);
        chk("midreset_resp_result", 64'(resp_result), 64'd0);

        // 64-bit, 4 bits per cycle
        issue(1, MD_OP_MUL, MD_OUT_LO, 0, 0, 64'h1_0000_0000, 64'd3, 1, 64'h3_0000_0000);
        wait_resp(1, lat, rdy);
        chk("latency64", 64'(lat), 64'd18);
        chk("ready_low64", 64'(rdy), 64'd0);
        issue(1, MD_OP_DIV, MD_OUT_LO, 1, 1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              1, 64'h8000_0000_0000_0000);
        wait_resp(1, lat, rdy);
        chk("latency64_ovf", 64'(lat), 64'd2);
        rr_random = 1;
        for (int i = 0; i < 60; i++) rand_req(1);

        for (int i = 0; i < 2000 && (sb32.size() + sb64.size()) != 0; i++) @(posedge clk);
        rr_random = 0;
        chk("drain_outstanding", 64'(sb32.size() + sb64.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
